// File: rtl/trb_pkg.sv
// Shared types and defaults for the trace-buffer capture controller.
package trb_pkg;

    typedef enum logic [1:0] {
        TRG_MODE_TRACE    = 2'b00,
        TRG_MODE_STREAM   = 2'b01,
        TRG_MODE_STREAM_B = 2'b10,
        TRG_MODE_STREAM_C = 2'b11
    } trg_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_POST,
        ST_DONE,
        ST_STREAM
    } cap_state_t;

    // Control defaults after reset: trace mode, post-trigger delay all ones.
    localparam trg_mode_t CTRL_MODE_DEFAULT = TRG_MODE_TRACE;
    localparam logic      CTRL_DELAY_BIT    = 1'b1;

    // Every encoding other than trace selects stream (FIFO) operation.
    function automatic logic is_stream(input trg_mode_t mode);
        return mode != TRG_MODE_TRACE;
    endfunction

endpackage

// File: rtl/trb_wrap_counter.sv
// AW-bit pointer with increment enable and synchronous clear; wraps modulo 2**AW.
module trb_wrap_counter #(
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [AW-1:0] cnt_o
);

    // Clear wins over increment so an arm always restarts from address 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i) begin
            cnt_o <= cnt_o + AW'(1);
        end
    end

endmodule

// File: rtl/trb_capture_ctrl.sv
// Trace-buffer capture controller: drives the BRAM write port from a sample
// stream in circular trace mode (pre/post trigger) or FIFO stream mode.
// Build option: TRB_TRIGGER_EDGE_EN selects rising-edge triggering of trg_i.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | not capturing; config and arm accepted
// ST_PRE    | circular pre-trigger capture, waiting for a qualified trigger
// ST_POST   | post-trigger capture, down-counting remaining samples
// ST_DONE   | trace complete, no writes; config and re-arm accepted
// ST_STREAM | FIFO mode, push from samples, pop from read side
module trb_capture_ctrl
    import trb_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int DEPTH      = 32,
    parameter  int DELAY_BITS = 8,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [DELAY_BITS-1:0] cfg_delay_i,
    input  logic                  arm_i,
    input  logic                  stop_i,
    input  logic                  data_valid_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  trg_i,
    input  logic                  rd_pop_i,
    output logic                  wr_en_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [WIDTH-1:0]      wr_data_o,
    output logic [AW-1:0]         rd_addr_o,
    output logic [AW:0]           fill_o,
    output logic                  trg_event_o,
    output logic [AW-1:0]         event_addr_o,
    output logic                  done_o,
    output logic                  overflow_o
);

    localparam int          CLAMP    = DEPTH - 1;
    localparam logic [AW:0] FILL_ONE = (AW+1)'(1);

    cap_state_t            state_q, state_nxt;
    trg_mode_t             cfg_mode_q, mode_eff;
    logic [DELAY_BITS-1:0] cfg_delay_q, cnt_q, cnt_nxt, cnt_load;
    logic [AW:0]           fill_q, fill_nxt;
    logic [AW-1:0]         wr_ptr, rd_ptr, event_addr_q, event_addr_nxt;
    logic                  trg_event_q, trg_event_nxt;
    logic                  done_q, done_nxt, overflow_q, overflow_nxt;
    logic                  ptr_clr, wr_acc, pop, push_ok, trg_hit, cfg_open, fill_full;
    logic                  wr_en_q;
    logic [AW-1:0]         wr_addr_q;
    logic [WIDTH-1:0]      wr_data_q;

`ifdef TRB_TRIGGER_EDGE_EN
    logic trg_prev_q;

    // Previous trigger level, tracked every cycle regardless of state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) trg_prev_q <= 1'b0;
        else       trg_prev_q <= trg_i;
    end

    assign trg_hit = data_valid_i & trg_i & ~trg_prev_q;
`else
    assign trg_hit = data_valid_i & trg_i;
`endif

    assign cfg_open  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign mode_eff  = cfg_valid_i ? trg_mode_t'(cfg_mode_i) : cfg_mode_q;
    assign fill_full = fill_q[AW];
    // Post count is clamped so the trigger sample can never be overwritten.
    assign cnt_load  = (int'(cfg_delay_q) > CLAMP) ? DELAY_BITS'(CLAMP) : cfg_delay_q;
    assign push_ok   = data_valid_i & (~fill_full | rd_pop_i);

    trb_wrap_counter #(.AW(AW)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (ptr_clr),
        .inc_i (wr_acc),
        .cnt_o (wr_ptr)
    );

    trb_wrap_counter #(.AW(AW)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (ptr_clr),
        .inc_i (pop),
        .cnt_o (rd_ptr)
    );

    // Next-state, pointer strobes and status updates.
    always_comb begin
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;
        fill_nxt       = fill_q;
        event_addr_nxt = event_addr_q;
        trg_event_nxt  = trg_event_q;
        done_nxt       = done_q;
        overflow_nxt   = overflow_q;
        ptr_clr        = 1'b0;
        wr_acc         = 1'b0;
        pop            = 1'b0;
        if (stop_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        ptr_clr       = 1'b1;
                        fill_nxt      = '0;
                        trg_event_nxt = 1'b0;
                        done_nxt      = 1'b0;
                        overflow_nxt  = 1'b0;
                        state_nxt     = is_stream(mode_eff) ? ST_STREAM : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (data_valid_i) begin
                        wr_acc   = 1'b1;
                        fill_nxt = fill_full ? fill_q : fill_q + FILL_ONE;
                        if (trg_hit) begin
                            trg_event_nxt  = 1'b1;
                            event_addr_nxt = wr_ptr;
                            cnt_nxt        = cnt_load;
                            if (cnt_load == '0) begin
                                state_nxt = ST_DONE;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (data_valid_i) begin
                        wr_acc   = 1'b1;
                        fill_nxt = fill_full ? fill_q : fill_q + FILL_ONE;
                        cnt_nxt  = cnt_q - DELAY_BITS'(1);
                        if (cnt_q == DELAY_BITS'(1)) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    wr_acc = push_ok;
                    pop    = rd_pop_i & (fill_q != '0);
                    if (data_valid_i & ~push_ok) overflow_nxt = 1'b1;
                    fill_nxt = fill_q + (push_ok ? FILL_ONE : '0) - (pop ? FILL_ONE : '0);
                    if (trg_hit & ~trg_event_q) begin
                        trg_event_nxt  = 1'b1;
                        event_addr_nxt = wr_ptr;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fill_q       <= '0;
            event_addr_q <= '0;
            trg_event_q  <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            fill_q       <= fill_nxt;
            event_addr_q <= event_addr_nxt;
            trg_event_q  <= trg_event_nxt;
            done_q       <= done_nxt;
            overflow_q   <= overflow_nxt;
        end
    end

    // Configuration is only writable while not capturing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_mode_q  <= CTRL_MODE_DEFAULT;
            cfg_delay_q <= {DELAY_BITS{CTRL_DELAY_BIT}};
        end else if (cfg_valid_i && cfg_open) begin
            cfg_mode_q  <= trg_mode_t'(cfg_mode_i);
            cfg_delay_q <= cfg_delay_i;
        end
    end

    // Registered BRAM write port, one cycle behind the accepted sample.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_acc;
            if (wr_acc) begin
                wr_addr_q <= wr_ptr;
                wr_data_q <= data_i;
            end
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    // A wrapped trace buffer's oldest word sits at the next write slot.
    assign rd_addr_o    = (state_q != ST_STREAM && fill_full) ? wr_ptr : rd_ptr;
    assign fill_o       = fill_q;
    assign trg_event_o  = trg_event_q;
    assign event_addr_o = event_addr_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;

endmodule
